// File: rtl/fifo_pkg.sv
// Shared definitions for both sides of the asynchronous FIFO.
// Holds the default pointer geometry and the Gray/binary conversions.
package fifo_pkg;

  localparam int FIFO_ADDR_WIDTH = 3;

  // Both conversions work on a 32-bit container, so narrower pointers zero-extend in and truncate out.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all
// Gray bits at or above it.
module fifo_gray2bin #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);

  logic [W-1:0] w_bin;

  always_comb begin
    w_bin        = '0;
    w_bin[W-1]   = i_gray[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      w_bin[i] = w_bin[i+1] ^ i_gray[i];
    end
  end

  assign o_bin = w_bin;

endmodule

// File: rtl/fifo_rd.sv
// Read-side controller of the asynchronous FIFO: read pointers, empty/occupancy
// flags and a first-word-fall-through output register, all in the read clock domain.
module fifo_rd
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int DATA_WIDTH = 8,
  parameter int AE_THRESH  = 1
) (
  input  logic                  R_CLK,
  input  logic                  R_RST,
  input  logic [ADDR_WIDTH:0]   rq2_wptr,
  input  logic [DATA_WIDTH-1:0] r_mem_data,
  input  logic                  r_ready,
  output logic                  r_valid,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_empty,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic [ADDR_WIDTH:0]   r_ptr,
  output logic [ADDR_WIDTH:0]   r_count,
  output logic                  r_almost_empty
);

  localparam int            PW       = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AE_LIMIT = PW'(AE_THRESH);

  logic [PW-1:0] r_bin;
  logic          w_pop;
  logic [PW-1:0] w_bin_next;
  logic [PW-1:0] w_gray_next;
  logic [PW-1:0] w_wbin;
  logic [PW-1:0] w_occ;

  // Handshake: a word transfers to the consumer on any edge where r_valid && r_ready.
  // The output register refills (pop) whenever memory is non-empty and the register
  // is either empty or being drained this same edge, giving one word per cycle.
  assign w_pop       = !r_empty && (!r_valid || r_ready);
  assign w_bin_next  = r_bin + {{ADDR_WIDTH{1'b0}}, w_pop};
  assign w_gray_next = PW'(bin2gray(32'(w_bin_next)));

  fifo_gray2bin #(.W(PW)) u_wptr_g2b (
    .i_gray (rq2_wptr),
    .o_bin  (w_wbin)
  );

  // Occupancy excludes the word already parked in the output register.
  assign w_occ  = w_wbin - w_bin_next;
  assign r_addr = r_bin[ADDR_WIDTH-1:0];

  always_ff @(posedge R_CLK) begin
    if (R_RST) begin
      r_bin          <= '0;
      r_ptr          <= '0;
      r_empty        <= 1'b1;
      r_count        <= '0;
      r_almost_empty <= 1'b1;
      r_valid        <= 1'b0;
      r_data         <= '0;
    end else begin
      r_bin          <= w_bin_next;
      r_ptr          <= w_gray_next;
      r_empty        <= (w_gray_next == rq2_wptr);
      r_count        <= w_occ;
      r_almost_empty <= (w_occ <= AE_LIMIT);
      if (w_pop) begin
        r_data  <= r_mem_data;
        r_valid <= 1'b1;
      end else if (r_valid && r_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fifo_rd.md
# fifo_rd

Read-side controller of the asynchronous FIFO, the counterpart of the write-side pointer/full block. It runs entirely in the read clock domain and keeps the binary and Gray read pointers. It derives `r_empty` from the write pointer, which is already synchronized into this domain, and drives the memory read address. A first-word-fall-through output register with a valid/ready handshake presents data to the consumer, alongside an occupancy count and an almost-empty flag.

## Interface
- `ADDR_WIDTH`, 3, memory address width; depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits
- `DATA_WIDTH`, 8, data word width
- `AE_THRESH`, 1, `r_almost_empty` asserts when the memory occupancy is at or below this value
- `R_CLK` in 1, read clock; single clock for the whole block
- `R_RST` in 1, reset; synchronous, active-high
- `rq2_wptr` in ADDR_WIDTH+1, Gray write pointer after the external 2-flop synchronizer
- `r_mem_data` in DATA_WIDTH, combinational memory read data at `r_addr`
- `r_ready` in 1, consumer accepts `r_data` this cycle
- `r_valid` out 1, `r_data` holds a valid word
- `r_data` out DATA_WIDTH, output register
- `r_empty` out 1, registered; memory holds no unread entries
- `r_addr` out ADDR_WIDTH, memory read address = `r_bin[ADDR_WIDTH-1:0]`
- `r_ptr` out ADDR_WIDTH+1, registered Gray read pointer, to the write-domain synchronizer
- `r_count` out ADDR_WIDTH+1, registered memory occupancy, 0..2^ADDR_WIDTH
- `r_almost_empty` out 1, registered, `r_count <= AE_THRESH`

## Operation
- `pop = !r_empty && (!r_valid || r_ready)`. This is combinational and internal, and it is the only event that advances the pointer.
- Pointer arithmetic:
  - `r_bin_next = r_bin + pop`, modulo 2^(ADDR_WIDTH+1)
  - `r_gray_next = (r_bin_next >> 1) ^ r_bin_next`
  - Registered: `r_bin <= r_bin_next`, `r_ptr <= r_gray_next`.
- `r_empty <= (r_gray_next == rq2_wptr)`. The comparison is a full-width equality, including the wrap MSB.
- Output register update:
  - On `pop`: `r_data <= r_mem_data` and `r_valid <= 1`.
  - Else if `r_valid && r_ready`: `r_valid <= 0`, and `r_data` holds its value.
  - Else both hold.
- Occupancy:
  - `w_bin = gray2bin(rq2_wptr)`
  - `r_count <= w_bin - r_bin_next`, modulo 2^(ADDR_WIDTH+1)
  - `r_almost_empty <= (w_bin - r_bin_next) <= AE_THRESH`
  - The word held in the output register is not counted.
- Simultaneous `r_valid && r_ready && pop`: the consumer takes the old word and the new word loads in the same edge; `r_valid` stays 1. This gives back-to-back throughput of 1 word per cycle.
- `r_ready` while `r_valid = 0` has no effect.
- `rq2_wptr` is treated as stale but monotonic. Empty may be reported pessimistically; no word is ever read twice or read before it is written.

## Timing
- Reset values, taken on an `R_CLK` edge with `R_RST = 1`:
  - `r_bin = 0`, `r_ptr = 0`, `r_addr = 0`
  - `r_empty = 1`, `r_valid = 0`, `r_data = 0`
  - `r_count = 0`, `r_almost_empty = 1`
- Reset mid-operation discards the output word and all pointers. The write side must be reset in the same window.
- Latency from `rq2_wptr` leaving the read pointer value (sampled at edge N):
  - `r_empty` falls after edge N+1.
  - `pop` occurs in cycle N+1, and `r_valid` rises after edge N+2.
- Draining the last entry: `pop` in cycle M gives `r_empty = 1` after edge M+1, and no further `pop`.
- Wrap: after 2^(ADDR_WIDTH+1) pops the pointer returns to 0. `r_addr` wraps every 2^ADDR_WIDTH pops.
- `r_count` and `r_almost_empty` lag `rq2_wptr` by 1 cycle.

## Structure
- A shared header/package, `fifo_pkg`, holds:
  - the default `ADDR_WIDTH`, shared by the write and read sides
  - `bin2gray`/`gray2bin` functions, which the write side uses too
- One sub-module, `fifo_gray2bin`: parameterized width, purely combinational XOR prefix, used for `w_bin`.
- The top level holds the pointer registers, the empty/count logic and the output stage.

## Test plan
All scenarios use `ADDR_WIDTH = 3`, `DATA_WIDTH = 8`, `AE_THRESH = 1`.
- **Reset:** hold `R_RST` for 2 cycles with `rq2_wptr = 5`. Required: all outputs at their reset values; `r_empty = 1` and `r_valid = 0` during reset.
- **Single word:** `rq2_wptr` 0 → 1 (Gray 0001), `r_mem_data = 8'hA5`, `r_ready = 0`.
  - `r_empty = 0` after 1 edge, then `r_valid = 1`, `r_data = A5`, `r_ptr = 0001`, `r_empty = 1`.
  - `r_valid` holds until `r_ready` rises; it falls 1 edge after.
- **Back-to-back:** `rq2_wptr = 4` (Gray 0110), `r_ready = 1` constantly, memory returns `10 + addr`.
  - `r_data` = 10, 11, 12, 13 on consecutive cycles, then `r_valid = 0`.
  - `r_count` steps 4, 3, 2, 1, 0.
  - `r_almost_empty` is 0 while `r_count` is 3 or above, and 1 once `r_count` is 1 or 0.
- **Backpressure:** 3 entries available, `r_ready = 0`.
  - Exactly 1 pop occurs; `r_count = 2` and holds.
  - Pulsing `r_ready` for 1 cycle yields exactly 1 further pop.
- **Wrap-around:** stream 20 words with `rq2_wptr` advancing in step.
  - `r_addr` follows 0..7, 0..7, 0..3.
  - `r_ptr` passes Gray 1000 after pop 15 and returns to 0000 after pop 16.
  - No false empty and no duplicate word.
- **Mid-stream reset:** apply `R_RST` while `r_valid = 1` and `r_count = 3`. Required: the next cycle shows the reset values; no pop occurs in the reset cycle.
